pio_write_arbiter: RTL and testbench
====================================

# pio_write_arbiter

Two-port arbiter and sequencer that shares one 7-bit Avalon-MM output PIO (data register at word address 0, bit-set at 4, bit-clear at 5) between two hardware requesters. Each requester posts a write, set, clear or toggle operation with a valid/ready handshake. The block grants requesters round-robin and drives the PIO slave port as an Avalon-MM master. Toggle is a read-modify-write sequence. The block sits between display/counter logic and the PIO slave in the Lab2 system.

## Interface
- DATA_W, 7, PIO data width; must match the PIO out_port width
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A valid
- op_a  in  2  A operation: 00 write, 01 set bits, 10 clear bits, 11 toggle bits
- data_a  in  DATA_W  A value or bit mask
- ack_a  out  1  A ready; a transfer completes on a clock edge where req_a && ack_a
- req_b, op_b, data_b, ack_b  same as A, for requester B
- m_address  out  3  PIO word address
- m_chipselect  out  1  PIO chipselect
- m_write_n  out  1  PIO write strobe, active low
- m_writedata  out  32  PIO write data: {zeros, DATA_W bits}
- m_readdata  in  32  PIO read data; only [DATA_W-1:0] used
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- All outputs are registered. Reset values: ack_a=0, ack_b=0, m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0, busy=0. The FSM resets to IDLE and rr_last resets to B, so A wins first.
- FSM states: IDLE, WRITE, READ, TWRITE.
- IDLE:
  - If neither request is pending, stay in IDLE.
  - If only one requester asserts req, grant it.
  - If both assert req, grant the one not equal to rr_last.
  - On the grant edge: set rr_last to the grantee and latch its op and data. Later changes to that requester's op/data are ignored.
  - Op 00/01/10 goes to WRITE. Op 11 goes to READ.
- WRITE (1 cycle):
  - m_chipselect=1, m_write_n=0, m_writedata=zero-extended data.
  - m_address: 0 for op 00, 4 for op 01, 5 for op 10.
  - ack of the grantee=1. Next state is IDLE.
- READ (1 cycle):
  - m_chipselect=1, m_write_n=1, m_address=0.
  - At the end of the cycle, capture m_readdata[DATA_W-1:0] (zero-wait combinational slave).
  - Next state is TWRITE.
- TWRITE (1 cycle):
  - m_chipselect=1, m_write_n=0, m_address=0.
  - m_writedata = captured ^ mask.
  - ack of the grantee=1. Next state is IDLE.
- In IDLE and between bus cycles: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- ack rules:
  - ack is a single-cycle pulse, only to the grantee, only in the final write cycle.
  - A requester must hold req/op/data stable until the ack edge.
  - A requester may present its next request on that same edge.
  - If req is still high in the following IDLE cycle, it is a new request.
- Exactly one bus write per accepted operation. There are no retries and no error path.
- Reset mid-operation: chipselect drops and ack clears asynchronously. The operation is abandoned with no ack and rr_last returns to B. The requester must re-post.

## Timing
- Write/set/clear: grant at edge N. The bus write and ack occupy cycle N..N+1. The block is back in IDLE at N+1, so one operation completes every 2 cycles.
- Toggle: grant at N, READ in cycle N..N+1, TWRITE and ack in cycle N+1..N+2. One operation completes every 3 cycles.
- Continuous requests from both sides: grants alternate strictly A, B, A, B.
- Starvation bound: a pending request is granted within one other operation (at most 3 cycles).
- busy is high for the WRITE, READ and TWRITE cycles and low in IDLE.
- Requests asserted while busy are held pending. They are evaluated in the next IDLE cycle.

## Test plan
- Reset: hold reset_n=0, then release with no requests. Required: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, ack_a=ack_b=0, busy=0, and they stay so.
- A writes: req_a, op 00, data 0x55. Required: in the cycle after grant, m_address=0, m_chipselect=1, m_write_n=0, m_writedata=0x00000055, ack_a pulses once; the PIO model reads 0x55.
- Set/clear against a PIO model holding 0x00:
  - B op 01, data 0x01 gives m_address=4 and the PIO reads 0x01.
  - Then A op 10, data 0x01 gives m_address=5 and the PIO reads 0x00.
- Toggle: PIO model holds 0x0F; B op 11, mask 0x3C. Required:
  - READ cycle: m_address=0, m_chipselect=1, m_write_n=1.
  - Next cycle: a write to address 0 with m_writedata=0x33 and ack_b=1.
  - The PIO reads 0x33. The operation spans 3 cycles from grant.
- Contention: req_a and req_b held high for 6 operations. Required: grants A,B,A,B,A,B; each ack pulses once per operation; no cycle has both acks high.
- Reset during toggle: assert reset_n=0 during READ. Required: m_chipselect falls without waiting for clk; no ack; the PIO value is unchanged. After release, with both requesting, A is granted first.

Source files
------------

// File: rtl/pio_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pio_write_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one Avalon-MM output PIO
//            (data @0, bit-set @4, bit-clear @5) between two requesters.
//            Write/set/clear take one bus write; toggle is read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module pio_write_arbiter #(
    parameter int DATA_W = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic [1:0]        op_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [1:0]        op_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    output logic              busy
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WRITE  = 2'd1;
    localparam logic [1:0] c_ST_READ   = 2'd2;
    localparam logic [1:0] c_ST_TWRITE = 2'd3;

    localparam logic [1:0] c_OP_SET    = 2'd1;
    localparam logic [1:0] c_OP_CLEAR  = 2'd2;
    localparam logic [1:0] c_OP_TOGGLE = 2'd3;

    localparam logic [2:0] c_ADDR_DATA  = 3'd0;
    localparam logic [2:0] c_ADDR_SET   = 3'd4;
    localparam logic [2:0] c_ADDR_CLEAR = 3'd5;

    localparam int c_PAD_W = 32 - DATA_W;

    logic [1:0]        r_state;
    logic              r_rr_last_b;   // 1: B was granted last, so A wins a tie
    logic              r_grant_b;     // current grantee (1 = B)
    logic [DATA_W-1:0] r_data;        // latched value / mask of the grantee
    logic              r_ack_a;
    logic              r_ack_b;
    logic [2:0]        r_address;
    logic              r_chipselect;
    logic              r_write_n;
    logic [31:0]       r_writedata;
    logic              r_busy;

    logic              w_grant_valid;
    logic              w_grant_b;
    logic [1:0]        w_sel_op;
    logic [DATA_W-1:0] w_sel_data;
    logic [2:0]        w_write_addr;
    logic [DATA_W-1:0] w_toggle_data;
    logic              w_unused_readdata;

    assign ack_a        = r_ack_a;
    assign ack_b        = r_ack_b;
    assign m_address    = r_address;
    assign m_chipselect = r_chipselect;
    assign m_write_n    = r_write_n;
    assign m_writedata  = r_writedata;
    assign busy         = r_busy;

    // Only the low DATA_W bits of the PIO readback carry state.
    assign w_unused_readdata = ^m_readdata[31:DATA_W];

    // B wins when it is the only requester or when A was served last.
    assign w_grant_valid = req_a | req_b;
    assign w_grant_b     = req_b & (~req_a | ~r_rr_last_b);
    assign w_sel_op      = w_grant_b ? op_b   : op_a;
    assign w_sel_data    = w_grant_b ? data_b : data_a;

    // The read data is sampled and combined with the mask in the same edge,
    // so the captured value lives directly in the write-data register.
    assign w_toggle_data = m_readdata[DATA_W-1:0] ^ r_data;

    // Map the selected operation onto the PIO register it targets.
    always_comb begin
        w_write_addr = c_ADDR_DATA;
        case (w_sel_op)
            c_OP_SET:   w_write_addr = c_ADDR_SET;
            c_OP_CLEAR: w_write_addr = c_ADDR_CLEAR;
            default:    w_write_addr = c_ADDR_DATA;
        endcase
    end

    // Sequencer: arbitrate in IDLE, then drive one registered bus cycle per state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_rr_last_b  <= 1'b1;
            r_grant_b    <= 1'b0;
            r_data       <= '0;
            r_ack_a      <= 1'b0;
            r_ack_b      <= 1'b0;
            r_address    <= c_ADDR_DATA;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            // Bus returns to idle levels unless a state below drives a cycle.
            r_ack_a      <= 1'b0;
            r_ack_b      <= 1'b0;
            r_address    <= c_ADDR_DATA;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= '0;
            r_busy       <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_rr_last_b  <= w_grant_b;
                        r_grant_b    <= w_grant_b;
                        r_data       <= w_sel_data;
                        r_chipselect <= 1'b1;
                        r_busy       <= 1'b1;
                        if (w_sel_op == c_OP_TOGGLE) begin
                            r_state <= c_ST_READ;
                        end else begin
                            r_state     <= c_ST_WRITE;
                            r_write_n   <= 1'b0;
                            r_address   <= w_write_addr;
                            r_writedata <= {{c_PAD_W{1'b0}}, w_sel_data};
                            r_ack_a     <= ~w_grant_b;
                            r_ack_b     <= w_grant_b;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_state <= c_ST_IDLE;
                end
                c_ST_READ: begin
                    r_state      <= c_ST_TWRITE;
                    r_chipselect <= 1'b1;
                    r_write_n    <= 1'b0;
                    r_writedata  <= {{c_PAD_W{1'b0}}, w_toggle_data};
                    r_ack_a      <= ~r_grant_b;
                    r_ack_b      <= r_grant_b;
                    r_busy       <= 1'b1;
                end
                c_ST_TWRITE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pio_write_arbiter
// Brief    : Self-checking bench for pio_write_arbiter with a PIO slave model,
//            directed scenarios and a randomized two-requester phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_write_arbiter;

    localparam int DATA_W = 7;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_a = 1'b0;
    logic [1:0]        op_a = '0;
    logic [DATA_W-1:0] data_a = '0;
    logic              ack_a;
    logic              req_b = 1'b0;
    logic [1:0]        op_b = '0;
    logic [DATA_W-1:0] data_b = '0;
    logic              ack_b;
    logic [2:0]        m_address;
    logic              m_chipselect;
    logic              m_write_n;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              busy;

    logic [DATA_W-1:0] pio = '0;   // PIO slave register
    logic [DATA_W-1:0] model_pio;  // value the PIO should hold
    int checks = 0;
    int errors = 0;

    // random-phase bookkeeping
    logic              rq   [2];
    logic [1:0]        rop  [2];
    logic [DATA_W-1:0] rdat [2];
    int                pres [2];
    bit                done [2];
    bit                pa   [0:4095];
    bit                pb   [0:4095];
    bit                last_b;
    bit                pio_due;
    bit                drain;
    int                cyc;

    always #5 clk = ~clk;

    pio_write_arbiter #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_a        (req_a),
        .op_a         (op_a),
        .data_a       (data_a),
        .ack_a        (ack_a),
        .req_b        (req_b),
        .op_b         (op_b),
        .data_b       (data_b),
        .ack_b        (ack_b),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .busy         (busy)
    );

    // Zero-wait PIO slave: data register, bit-set and bit-clear ports.
    assign m_readdata = {25'd0, pio};
    always @(posedge clk) begin
        if (m_chipselect && !m_write_n) begin
            case (m_address)
                3'd0:    pio <= m_writedata[DATA_W-1:0];
                3'd4:    pio <= pio | m_writedata[DATA_W-1:0];
                3'd5:    pio <= pio & ~m_writedata[DATA_W-1:0];
                default: ;
            endcase
        end
    end

    function automatic logic [DATA_W-1:0] apply_op(input logic [DATA_W-1:0] cur,
                                                   input logic [1:0] op,
                                                   input logic [DATA_W-1:0] d);
        case (op)
            2'd0:    return d;
            2'd1:    return cur | d;
            2'd2:    return cur & ~d;
            default: return cur ^ d;
        endcase
    endfunction

    function automatic logic [2:0] op_addr(input logic [1:0] op);
        return (op == 2'd1) ? 3'd4 : (op == 2'd2) ? 3'd5 : 3'd0;
    endfunction

    function automatic logic [31:0] op_wdata(input logic [DATA_W-1:0] cur,
                                             input logic [1:0] op,
                                             input logic [DATA_W-1:0] d);
        return {25'd0, (op == 2'd3) ? (cur ^ d) : d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cs"},    32'(m_chipselect), 32'd0);
        check({tag, "_wn"},    32'(m_write_n),    32'd1);
        check({tag, "_addr"},  32'(m_address),    32'd0);
        check({tag, "_wdata"}, m_writedata,       32'd0);
        check({tag, "_ack_a"}, 32'(ack_a),        32'd0);
        check({tag, "_ack_b"}, 32'(ack_b),        32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
    endtask

    // One isolated operation from one requester, checked cycle by cycle.
    task automatic do_op(input bit who_b, input logic [1:0] op,
                         input logic [DATA_W-1:0] d, input string tag);
        logic [DATA_W-1:0] exp_pio;
        exp_pio = apply_op(model_pio, op, d);
        if (who_b) begin req_b = 1'b1; op_b = op; data_b = d; end
        else       begin req_a = 1'b1; op_a = op; data_a = d; end
        tick;
        if (op == 2'd3) begin
            check({tag, "_rd_cs"},   32'(m_chipselect), 32'd1);
            check({tag, "_rd_wn"},   32'(m_write_n),    32'd1);
            check({tag, "_rd_addr"}, 32'(m_address),    32'd0);
            check({tag, "_rd_acks"}, 32'({ack_a, ack_b}), 32'd0);
            tick;
        end
        check({tag, "_cs"},    32'(m_chipselect), 32'd1);
        check({tag, "_wn"},    32'(m_write_n),    32'd0);
        check({tag, "_addr"},  32'(m_address),    32'(op_addr(op)));
        check({tag, "_wdata"}, m_writedata,       op_wdata(model_pio, op, d));
        check({tag, "_ack_a"}, 32'(ack_a),        32'(!who_b));
        check({tag, "_ack_b"}, 32'(ack_b),        32'(who_b));
        check({tag, "_busy"},  32'(busy),         32'd1);
        tick;
        if (who_b) req_b = 1'b0; else req_a = 1'b0;
        check({tag, "_ack_done"}, 32'({ack_a, ack_b}), 32'd0);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_pio"}, 32'(pio), 32'(exp_pio));
        model_pio = exp_pio;
    endtask

    task automatic new_req(input int x);
        rq[x]   = 1'b1;
        rop[x]  = 2'($urandom_range(0, 3));
        rdat[x] = DATA_W'($urandom);
        pres[x] = cyc;
    endtask

    task automatic drive_rand;
        req_a = rq[0]; op_a = rop[0]; data_a = rdat[0];
        req_b = rq[1]; op_b = rop[1]; data_b = rdat[1];
        pa[cyc] = rq[0];
        pb[cyc] = rq[1];
    endtask

    initial begin
        model_pio = '0;

        // reset
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
        repeat (3) tick;
        check_idle("post_reset");

        // basic write, then set/clear from 0x00, then toggle from 0x0F
        do_op(1'b0, 2'd0, 7'h55, "a_write");
        do_op(1'b0, 2'd0, 7'h00, "a_zero");
        do_op(1'b1, 2'd1, 7'h01, "b_set");
        do_op(1'b0, 2'd2, 7'h01, "a_clear");
        do_op(1'b0, 2'd0, 7'h0F, "a_preset");
        do_op(1'b1, 2'd3, 7'h3C, "b_toggle");
        check("toggle_result", 32'(pio), 32'h33);

        // contention: both held high for 6 operations
        req_a = 1'b1; op_a = 2'd0; data_a = 7'h11;
        req_b = 1'b1; op_b = 2'd0; data_b = 7'h22;
        for (int i = 0; i < 6; i++) begin
            tick;
            check($sformatf("cont%0d_ack_a", i), 32'(ack_a), 32'(i % 2 == 0));
            check($sformatf("cont%0d_ack_b", i), 32'(ack_b), 32'(i % 2 == 1));
            check($sformatf("cont%0d_wdata", i), m_writedata, (i % 2 == 0) ? 32'h11 : 32'h22);
            tick;
            check($sformatf("cont%0d_acks_low", i), 32'({ack_a, ack_b}), 32'd0);
            check($sformatf("cont%0d_pio", i), 32'(pio), (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        req_a = 1'b0; req_b = 1'b0;
        model_pio = 7'h22;
        tick;
        check_idle("cont_end");

        // reset in the READ cycle of a toggle
        req_b = 1'b1; op_b = 2'd3; data_b = 7'h3C;
        tick;
        check("rst_read_cs", 32'(m_chipselect), 32'd1);
        check("rst_read_wn", 32'(m_write_n), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_cs", 32'(m_chipselect), 32'd0);
        check("rst_async_ack_b", 32'(ack_b), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        req_b = 1'b0;
        repeat (2) tick;
        check("rst_pio_kept", 32'(pio), 32'(model_pio));
        reset_n = 1'b1;
        req_a = 1'b1; op_a = 2'd0; data_a = 7'h11;
        req_b = 1'b1; op_b = 2'd0; data_b = 7'h22;
        tick;
        check("rst_first_ack_a", 32'(ack_a), 32'd1);
        check("rst_first_ack_b", 32'(ack_b), 32'd0);
        tick;
        req_a = 1'b0; req_b = 1'b0;
        check("rst_first_pio", 32'(pio), 32'h11);
        model_pio = 7'h11;
        last_b = 1'b0;
        tick;

        // randomized traffic from both requesters
        cyc = 0;
        pio_due = 1'b0;
        drain = 1'b0;
        for (int x = 0; x < 2; x++) begin
            rq[x] = 1'b0; rop[x] = '0; rdat[x] = '0; pres[x] = 0; done[x] = 1'b0;
        end
        drive_rand;
        for (int k = 1; k < 3000; k++) begin
            tick;
            cyc = k;
            drain = (k >= 2940);
            check("rand_both_acks", 32'(ack_a & ack_b), 32'd0);
            if (pio_due) begin
                check("rand_pio", 32'(pio), 32'(model_pio));
                pio_due = 1'b0;
            end
            for (int x = 0; x < 2; x++) begin
                logic a;
                int   gi;
                a = (x == 0) ? ack_a : ack_b;
                if (a) begin
                    gi = cyc - ((rop[x] == 2'd3) ? 2 : 1);
                    check($sformatf("rand_req_posted_%0d", x), 32'(rq[x] && pres[x] <= gi), 32'd1);
                    if (pa[gi] && pb[gi])
                        check("rand_rr_winner", 32'(x), 32'(!last_b));
                    check($sformatf("rand_latency_%0d", x), 32'(cyc - pres[x] <= 5), 32'd1);
                    check("rand_wn", 32'(m_write_n), 32'd0);
                    check("rand_cs", 32'(m_chipselect), 32'd1);
                    check("rand_addr", 32'(m_address), 32'(op_addr(rop[x])));
                    check("rand_wdata", m_writedata, op_wdata(model_pio, rop[x], rdat[x]));
                    model_pio = apply_op(model_pio, rop[x], rdat[x]);
                    last_b = (x == 1);
                    done[x] = 1'b1;
                    pio_due = 1'b1;
                end else if (done[x]) begin
                    done[x] = 1'b0;
                    if (!drain && $urandom_range(0, 3) != 0) new_req(x);
                    else rq[x] = 1'b0;
                end else if (!rq[x] && !drain && $urandom_range(0, 1) == 1) begin
                    new_req(x);
                end else if (rq[x]) begin
                    check($sformatf("rand_starve_%0d", x), 32'(cyc - pres[x] <= 5), 32'd1);
                end
            end
            drive_rand;
        end
        tick;
        check("final_req_a_done", 32'(rq[0]), 32'd0);
        check("final_req_b_done", 32'(rq[1]), 32'd0);
        check("final_busy", 32'(busy), 32'd0);
        check("final_pio", 32'(pio), 32'(model_pio));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
